// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter driving a one-hot decoded grant for 4 requesters.
// Optional tenure limit with timeout pulse: define RR_ARB_TIMEOUT_EN.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state, state_n;
  logic [1:0]         ptr, ptr_n, idx_n;
  logic [CNT_W-1:0]   hold_cnt, cnt_n;
  logic               to_n;
  logic               owner_req;
  logic               expire;
  logic [3:0]         mask;
  logic [2:0]         win;

  // {found, index}: first set bit of m searching p, p+1, ... mod 4
  function automatic logic [2:0] pick(input logic [3:0] m,
                                      input logic [1:0] p);
    logic [2:0] r;
    logic [1:0] i;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      i = p + 2'(k);
      if (m[i]) r = {1'b1, i};
    end
    return r;
  endfunction

  always_comb begin
    state_n   = state;
    idx_n     = grant_idx;
    ptr_n     = ptr;
    cnt_n     = hold_cnt;
    to_n      = 1'b0;
    owner_req = req[grant_idx];
`ifdef RR_ARB_TIMEOUT_EN
    expire    = (state == OWN) && owner_req &&
                (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
    expire    = 1'b0;
`endif
    mask      = expire ? (req & ~(4'b0001 << grant_idx)) : req;
    win       = pick(mask, ptr);
    if (state == IDLE || !owner_req || expire) begin
      to_n  = expire;
      cnt_n = '0;
      if (win[2]) begin
        state_n = OWN;
        idx_n   = win[1:0];
        ptr_n   = win[1:0] + 2'd1;
      end else begin
        state_n = IDLE;
        idx_n   = 2'd0;
      end
    end else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
      cnt_n = hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      grant_idx <= 2'd0;
      grant     <= 4'b0000;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= cnt_n;
      grant_idx <= idx_n;
      grant     <= (state_n == OWN) ? (4'b0001 << idx_n) : 4'b0000;
      busy      <= (state_n == OWN);
      timeout   <= to_n;
    end
  end

endmodule
